seq_detector_prog: RTL and testbench
====================================

SEQ_DETECTOR_PROG -- requirements
Module: seq_detector_prog

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 SHALL have parameter CNT_W, default 16: match counter width.
REQ-003 SHALL have derived width LEN_W = $clog2(MAX_LEN+1).
REQ-004 SHALL have port Clk, input, 1: clock; all state changes on posedge.
REQ-005 SHALL have port Rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port Din_valid, input, 1: Din qualifier; no history change when low.
REQ-007 SHALL have port Din, input, 1: serial data bit.
REQ-008 SHALL have port Cfg_we, input, 1: one-cycle pulse that loads the four Cfg_* ports.
REQ-009 SHALL have port Cfg_pattern, input, MAX_LEN: pattern bits; bit [len-1] is received first and bit [0] last.
REQ-010 SHALL have port Cfg_len, input, LEN_W: pattern length; legal values are 1..MAX_LEN.
REQ-011 SHALL have port Cfg_overlap, input, 1: 1 = overlapping matches, 0 = non-overlapping.
REQ-012 SHALL have port Cfg_registered, input, 1: 0 = Mealy output, 1 = registered output.
REQ-013 SHALL have port Y, output, 1: match pulse.
REQ-014 SHALL have port Match_count, output, CNT_W: saturating count of matches.
REQ-015 SHALL have port Armed, output, 1: high when the stored length is in 1..MAX_LEN.

Function
REQ-016 SHALL keep a history shift register hist[MAX_LEN-2:0]; on each valid bit it SHALL shift left with Din entering bit 0.
REQ-017 SHALL keep a fill counter, 0..MAX_LEN-1; it SHALL increment on each valid bit, saturate at MAX_LEN-1, and track how many history bits are meaningful.
REQ-018 match_now SHALL = Din_valid & Armed & (fill >= len-1) & ({hist[len-2:0],Din} == pat[len-1:0]); when len=1, match_now SHALL reduce to Din_valid & (Din == pat[0]).
REQ-019 Mealy mode: Y SHALL = match_now combinationally, asserting in the same cycle as the final pattern bit.
REQ-020 Registered mode: Y SHALL be a flop of match_now, asserting exactly 1 cycle after the final bit, for 1 cycle per match.
REQ-021 Overlap mode: fill SHALL update normally on a match, so the match tail can start the next match.
REQ-022 Non-overlap mode: on match_now, fill SHALL be cleared to 0, so bits of the matched sequence are never reused.
REQ-023 On match_now, Match_count SHALL increment by 1 and hold at 2^CNT_W-1, never wrapping.
REQ-024 When Din_valid=0, hist, fill, Match_count and the Y flop input SHALL all be held, and the Mealy Y SHALL be 0.
REQ-025 Cfg_we=1 SHALL, at the clock edge, load pat, len, overlap and registered mode, and clear fill, the Y flop and Match_count.
REQ-026 Din in the same cycle as Cfg_we SHALL be ignored, and match_now SHALL be forced to 0 in that cycle.
REQ-027 Cfg_len=0 or Cfg_len>MAX_LEN SHALL be stored as-is; it SHALL drive Armed=0 and produce no matches.
REQ-028 Cfg_pattern bits at or above len SHALL be don't-care.

Reset
REQ-029 Rst=1 SHALL, at the clock edge, set pat=4'b1101 zero-extended, len=4, overlap=1, registered=0.
REQ-030 Rst=1 SHALL also set fill=0, hist=0, Y flop=0 and Match_count=0; Armed SHALL then be 1.
REQ-031 Rst SHALL take priority over Cfg_we and Din_valid, and a partial sequence in progress SHALL be discarded.
REQ-032 After reset, the block SHALL detect 1101 with overlap and a Mealy output.

Structure
REQ-033 Package seqdet_pkg SHALL hold DEFAULT_PATTERN (1101), DEFAULT_LEN (4) and a LEN_W helper function.
REQ-034 Sub-module seqdet_sat_cnt (parameter W; inputs clr, inc; output cnt) SHALL implement the saturating match counter.
REQ-035 Pattern comparison SHALL use a masked compare over MAX_LEN bits; no per-length case statement.

Verification
REQ-036 Reset defaults, Din=1,1,0,1,1,0,1 valid every cycle -> Y=1 on bits 4 and 7; Match_count=2.
REQ-037 Cfg_overlap=0 with the same stream -> Y=1 on bit 4 only, Match_count=1; appending 1,1,0,1 gives a second match on the new final 1.
REQ-038 Cfg_registered=1, pattern 1101 -> Y=1 one cycle after bit 4, 0 otherwise; Din_valid low gaps inside the sequence -> match still detected.
REQ-039 MAX_LEN=8, Cfg_len=8, pattern 8'hA5, stream A5A5 MSB-first -> 2 matches overlapping, 2 non-overlapping; Cfg_len=1, pattern 1 -> Y on every valid 1.
REQ-040 CNT_W=3, 9 matches -> Match_count holds 7; Cfg_we mid-stream -> count=0, next match needs a full len bits after the load.
REQ-041 Rst after bits 1,1,0, then Din=1 -> no match; Cfg_len=0 -> Armed=0, no Y on any stream.

Source files
------------

// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared constants, mode types and helpers for seq_detector_prog.
//   DEFAULT_PATTERN / DEFAULT_LEN : pattern loaded at reset (1101, 4 bits)
//   out_mode_e                    : Mealy or registered match output
//   overlap_mode_e                : overlapping or disjoint matching
//   len_w()                       : width needed to hold a length 0..max_len
package seqdet_pkg;

    localparam logic [31:0] DEFAULT_PATTERN = 32'b1101;
    localparam int unsigned DEFAULT_LEN     = 4;

    typedef enum logic {
        OUT_MEALY      = 1'b0,
        OUT_REGISTERED = 1'b1
    } out_mode_e;

    typedef enum logic {
        MATCH_DISJOINT = 1'b0,
        MATCH_OVERLAP  = 1'b1
    } overlap_mode_e;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seqdet_sat_cnt.sv
// seqdet_sat_cnt: saturating up-counter for detected matches.
//   Clk : clock, rising edge
//   Rst : synchronous active-high reset, clears the count
//   clr : synchronous clear (configuration reload)
//   inc : count one event; ignored once the count is all-ones
//   cnt : current count, holds at 2^W-1
module seqdet_sat_cnt #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge Clk) begin
        if (Rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: programmable serial bit-sequence detector.
//   Clk            : clock, all state changes on rising edge
//   Rst            : synchronous active-high reset (loads 1101/len 4/overlap/Mealy)
//   Din_valid, Din : qualified serial input bit
//   Cfg_we         : one-cycle load of Cfg_pattern/Cfg_len/Cfg_overlap/Cfg_registered
//   Cfg_pattern    : pattern, bit [len-1] arrives first, bit [0] last
//   Cfg_len        : pattern length, legal 1..MAX_LEN (others disarm the block)
//   Cfg_overlap    : 1 = overlapping matches, 0 = disjoint matches
//   Cfg_registered : 1 = Y delayed one cycle through a flop, 0 = Mealy Y
//   Y              : match pulse
//   Match_count    : saturating number of matches since reset/load
//   Armed          : stored length is legal
module seq_detector_prog
    import seqdet_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 16,
    localparam int LEN_W   = len_w(MAX_LEN)
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Din_valid,
    input  logic               Din,
    input  logic               Cfg_we,
    input  logic [MAX_LEN-1:0] Cfg_pattern,
    input  logic [LEN_W-1:0]   Cfg_len,
    input  logic               Cfg_overlap,
    input  logic               Cfg_registered,
    output logic               Y,
    output logic [CNT_W-1:0]   Match_count,
    output logic               Armed
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    overlap_mode_e      ovl_q;
    out_mode_e          omode_q;

    logic [MAX_LEN-2:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic               y_q;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_ext;
    logic               fill_ok;
    logic               pat_eq;
    logic               match_now;

    // Newest bit sits at window[0], so window[len-1:0] lines up with
    // pat[len-1:0] directly; the mask hides pattern bits at or above len.
    always_comb begin
        window = {hist_q, Din};
        mask   = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < 32'(len_q));
        end
        pat_eq = (((window ^ pat_q) & mask) == '0);

        Armed = (len_q != '0) && (len_q <= LEN_W'(MAX_LEN));

        // fill >= len-1 rewritten as fill+1 >= len to avoid underflow at len=0
        fill_ext = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
        fill_ok  = (fill_ext >= {1'b0, len_q});

        match_now = Din_valid && !Cfg_we && Armed && fill_ok && pat_eq;

        Y = (omode_q == OUT_REGISTERED) ? y_q : match_now;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pat_q   <= DEFAULT_PATTERN[MAX_LEN-1:0];
            len_q   <= LEN_W'(DEFAULT_LEN);
            ovl_q   <= MATCH_OVERLAP;
            omode_q <= OUT_MEALY;
            hist_q  <= '0;
            fill_q  <= '0;
            y_q     <= 1'b0;
        end else if (Cfg_we) begin
            pat_q   <= Cfg_pattern;
            len_q   <= Cfg_len;
            ovl_q   <= overlap_mode_e'(Cfg_overlap);
            omode_q <= out_mode_e'(Cfg_registered);
            fill_q  <= '0;
            y_q     <= 1'b0;
        end else begin
            // match_now is 0 whenever Din_valid is low, so the flop
            // yields exactly one pulse per match
            y_q <= match_now;
            if (Din_valid) begin
                hist_q <= window[MAX_LEN-2:0];
                if (match_now && (ovl_q == MATCH_DISJOINT)) begin
                    fill_q <= '0;
                end else if (fill_q != FILL_MAX) begin
                    fill_q <= fill_q + LEN_W'(1);
                end
            end
        end
    end

    seqdet_sat_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .Clk (Clk),
        .Rst (Rst),
        .clr (Cfg_we),
        .inc (match_now),
        .cnt (Match_count)
    );

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed bench for seq_detector_prog with a
// queue-based reference model checked every cycle on the falling edge.
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 3;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               Clk = 1'b0;
    logic               Rst = 1'b1;
    logic               Din_valid = 1'b0;
    logic               Din = 1'b0;
    logic               Cfg_we = 1'b0;
    logic [MAX_LEN-1:0] Cfg_pattern = '0;
    logic [LEN_W-1:0]   Cfg_len = '0;
    logic               Cfg_overlap = 1'b0;
    logic               Cfg_registered = 1'b0;
    logic               Y;
    logic [CNT_W-1:0]   Match_count;
    logic               Armed;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] ylog;

    seq_detector_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Din_valid      (Din_valid),
        .Din            (Din),
        .Cfg_we         (Cfg_we),
        .Cfg_pattern    (Cfg_pattern),
        .Cfg_len        (Cfg_len),
        .Cfg_overlap    (Cfg_overlap),
        .Cfg_registered (Cfg_registered),
        .Y              (Y),
        .Match_count    (Match_count),
        .Armed          (Armed)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bits received since the last clear, oldest first.
    bit          mq[$];
    logic [7:0]  m_pat;
    int          m_len;
    bit          m_ovl, m_reg, m_prev, m_valid = 0;
    int          m_cnt;

    always @(negedge Clk) begin : cmp
        bit m;
        bit b;
        int n;
        m = 0;
        if (Din_valid && !Cfg_we && m_len >= 1 && m_len <= MAX_LEN && mq.size() + 1 >= m_len) begin
            m = 1;
            n = mq.size();
            for (int k = 0; k < m_len; k++) begin
                b = (k == 0) ? Din : mq[n - k];
                if (b != m_pat[k]) m = 0;
            end
        end
        if (m_valid && !Rst) begin
            chk("Y", {31'b0, Y}, {31'b0, (m_reg ? m_prev : m)});
            chk("Match_count", {29'b0, Match_count}, m_cnt);
            chk("Armed", {31'b0, Armed}, {31'b0, (m_len >= 1 && m_len <= MAX_LEN)});
        end
        if (Rst) begin
            m_pat = 8'b0000_1101; m_len = 4; m_ovl = 1; m_reg = 0;
            mq.delete(); m_cnt = 0; m_prev = 0; m_valid = 1;
        end else if (Cfg_we) begin
            m_pat = Cfg_pattern; m_len = int'(Cfg_len);
            m_ovl = Cfg_overlap; m_reg = Cfg_registered;
            mq.delete(); m_cnt = 0; m_prev = 0;
        end else begin
            m_prev = m;
            if (Din_valid) begin
                if (m && !m_ovl) mq.delete();
                else mq.push_back(Din);
                if (mq.size() > MAX_LEN) void'(mq.pop_front());
                if (m && m_cnt < CNT_MAX) m_cnt++;
            end
        end
    end

    // All tasks start and end just after a rising edge.
    task automatic step(input bit v, input bit d);
        Din_valid = v;
        Din = d;
        @(negedge Clk);
        #1;
        ylog = {ylog[30:0], Y};
        @(posedge Clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i]);
        Din_valid = 1'b0;
    endtask

    task automatic cfg(input logic [7:0] p, input int l, input bit ovl, input bit rg);
        Cfg_we = 1'b1; Cfg_pattern = p; Cfg_len = LEN_W'(l);
        Cfg_overlap = ovl; Cfg_registered = rg;
        Din_valid = 1'b1; Din = 1'b1;
        @(posedge Clk);
        #1;
        Cfg_we = 1'b0; Din_valid = 1'b0; Din = 1'b0;
        ylog = '0;
    endtask

    task automatic rst_pulse();
        Rst = 1'b1; Din_valid = 1'b1; Din = 1'b1; Cfg_we = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0; Din_valid = 1'b0; Din = 1'b0; Cfg_we = 1'b0;
        ylog = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ylog = '0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;

        chk("reset_count", {29'b0, Match_count}, 0);
        chk("reset_armed", {31'b0, Armed}, 1);
        chk("reset_y", {31'b0, Y}, 0);

        // Default 1101, overlap, Mealy
        ylog = '0;
        feed(32'b1101101, 7);
        chk("dflt_y", ylog, 32'b0001001);
        chk("dflt_cnt", {29'b0, Match_count}, 2);

        // Disjoint matching
        cfg(8'h0D, 4, 0, 0);
        feed(32'b1101101, 7);
        chk("disj_y", ylog, 32'b0001000);
        chk("disj_cnt", {29'b0, Match_count}, 1);
        ylog = '0;
        feed(32'b1101, 4);
        chk("disj_y2", ylog, 32'b0001);
        chk("disj_cnt2", {29'b0, Match_count}, 2);

        // Registered output with valid gaps
        cfg(8'h0D, 4, 1, 1);
        step(1, 1); step(0, 0); step(1, 1); step(0, 1);
        step(1, 0); step(1, 1); step(0, 0); step(0, 0);
        chk("reg_y", ylog, 32'b00000010);
        chk("reg_cnt", {29'b0, Match_count}, 1);

        // Full-length pattern A5
        cfg(8'hA5, 8, 1, 0);
        feed(32'hA5A5, 16);
        chk("a5_ovl_y", ylog, 32'h0101);
        chk("a5_ovl_cnt", {29'b0, Match_count}, 2);
        cfg(8'hA5, 8, 0, 0);
        feed(32'hA5A5, 16);
        chk("a5_disj_cnt", {29'b0, Match_count}, 2);

        // Length 1
        cfg(8'h01, 1, 1, 0);
        feed(32'b1011, 4);
        chk("len1_y", ylog, 32'b1011);
        chk("len1_cnt", {29'b0, Match_count}, 3);

        // Saturation
        cfg(8'h01, 1, 1, 0);
        feed(32'h1FF, 9);
        chk("sat_cnt", {29'b0, Match_count}, 7);

        // Reload mid-stream clears history use and count
        cfg(8'h0D, 4, 1, 0);
        feed(32'b1101, 4);
        feed(32'b11, 2);
        cfg(8'h0D, 4, 1, 0);
        feed(32'b01, 2);
        chk("reload_y", ylog, 32'b0);
        chk("reload_cnt", {29'b0, Match_count}, 0);
        ylog = '0;
        feed(32'b1101, 4);
        chk("reload_y2", ylog, 32'b0001);
        chk("reload_cnt2", {29'b0, Match_count}, 1);

        // Reset discards partial sequence
        ylog = '0;
        feed(32'b110, 3);
        rst_pulse();
        feed(32'b1, 1);
        chk("rst_y", ylog, 32'b0);
        chk("rst_cnt", {29'b0, Match_count}, 0);
        chk("rst_armed", {31'b0, Armed}, 1);

        // Illegal lengths disarm
        cfg(8'h0D, 0, 1, 0);
        chk("len0_armed", {31'b0, Armed}, 0);
        feed(32'b1101101, 7);
        chk("len0_y", ylog, 32'b0);
        chk("len0_cnt", {29'b0, Match_count}, 0);
        cfg(8'hFF, 9, 1, 0);
        chk("len9_armed", {31'b0, Armed}, 0);
        feed(32'hFFFF, 16);
        chk("len9_y", ylog, 32'b0);

        step(0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
